vga_timing_monitor: RTL and testbench
=====================================

# vga_timing_monitor

Passive checker for the 640x480 VGA output path. It sits directly downstream of the VGA driver and taps the same video_de / video_hs / video_vs / video_rgb nets that leave the chip. It measures line and frame geometry and a per-frame pixel checksum, compares them against the expected timing, and reports lock status and sticky error flags. It drives nothing back into the video path.

## Interface
- H_TOTAL, 800: expected pixel_clk cycles per line (hs edge to hs edge)
- H_ACTIVE, 640: expected de-high cycles per active line
- V_TOTAL, 525: expected lines per frame (vs edge to vs edge)
- V_ACTIVE, 480: expected lines containing de-high cycles
- HS_POL, 0: active level of video_hs (0 = active-low)
- VS_POL, 0: active level of video_vs (0 = active-low)
- pixel_clk  in  1  pixel clock; single clock domain for the block
- sys_rst_n  in  1  reset, asynchronous, active-low
- video_de  in  1  data enable from driver
- video_hs  in  1  horizontal sync
- video_vs  in  1  vertical sync
- video_rgb  in  6  pixel data, valid when video_de=1
- frame_done  out  1  one-cycle pulse when a full frame's results are latched
- meas_htotal  out  12  length in cycles of the last line of the frame
- meas_hactive  out  12  de count of the last line with nonzero de
- meas_vtotal  out  12  lines in the frame
- meas_vactive  out  12  lines with nonzero de count
- frame_sum  out  16  sum of video_rgb over de-high cycles, mod 2^16
- locked  out  1  last completed frame matched all four parameters
- err_flags  out  4  sticky: [0] line length≠H_TOTAL, [1] active line de count≠H_ACTIVE, [2] vtotal≠V_TOTAL, [3] vactive≠V_ACTIVE

## Operation
- Input stage: all four inputs are registered once, and then registered again for edge detection. An hs edge is the transition into HS_POL. A vs edge is the transition into VS_POL.
- Line counter cyc: increments every cycle and saturates at 4095. On an hs edge, line_len is set to the number of cycles since the previous hs edge. The counter then restarts so that the next latch is exact (800 for an ideal stream).
- de counter: counts registered de-high cycles since the previous hs edge. It is latched and cleared on the hs edge.
- On each hs edge, the line is closed:
  - The line count increments.
  - If the de count is nonzero, the active-line count increments. If it is also ≠ H_ACTIVE, set err[1].
  - If line_len ≠ H_TOTAL, set err[0]. Exception: err[0] is not set for the first line after SEEK.
- Checksum accumulator: adds the registered rgb (zero-extended) on each de-high cycle and wraps mod 2^16.
- On a vs edge, the frame is closed. Accumulators are cleared for the next frame.
- Same-cycle hs and vs edges: the line is closed first and is counted into the frame being closed.
- FSM states:
  - SEEK (reset state): ignore data. On a vs edge, clear accumulators and go to MEASURE. No frame_done.
  - MEASURE: on a vs edge, latch all meas_*/frame_sum and pulse frame_done. Set err[2]/err[3] on mismatch. If all four values match and no err[0]/err[1] event occurred this frame, go to LOCKED with locked=1. Otherwise stay in MEASURE.
  - LOCKED: same latch, pulse and flag behaviour as MEASURE. On any mismatch in the frame, go to MEASURE with locked=0.
- err_flags are cleared only by reset.
- Reset values: frame_done=0, all meas_*=0, frame_sum=0, locked=0, err_flags=0, FSM=SEEK, all counters 0.
- Reset asserted mid-frame: the partial frame is discarded. The first frame after release is again skipped in SEEK.

## Timing
- Input sampled at edge k. Edge detected during cycle k→k+1. Counters and outputs update at edge k+1.
- frame_done is high for exactly one cycle, starting after edge k+1 of the vs-edge sample. meas_*, frame_sum and locked are valid in that same cycle and hold until the next frame close.
- A de-high pixel sampled at edge k is included in the frame in which it is sampled. A pixel sampled in the same cycle as a vs edge belongs to the closing frame.
- Throughput: a continuous stream is monitored with no dead cycles, and back-to-back frames are all measured.

## Test plan
- Ideal 640x480 stream (800/640/525/480, active-low syncs), 3 frames, rgb=6'h3F on all active pixels → frame_done pulses at the ends of frames 2 and 3. Each pulse shows meas 800/640/525/480 and frame_sum=16'h5000. locked=1 after the first pulse. err_flags=0.
- Ideal stream with rgb=0 → frame_sum=0 and locked=1.
- Frame 3 contains one line of 799 cycles → err[0]=1 at that line. At the frame 3 close, locked=0 and the FSM is in MEASURE. Frame 4 ideal → locked=1 again, and err[0] stays 1.
- One active line with de high for 639 cycles → err[1]=1 and locked drops at that frame close. meas_vactive=480.
- hs and vs edges forced into the same cycle → that line is counted in the closing frame. meas_vtotal=525 for the ideal stream.
- sys_rst_n pulsed low mid-frame 2 → all outputs are 0 immediately (asynchronous). The next vs edge produces no frame_done. The first frame_done appears one full frame later with correct values.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Passive checker for a VGA output path: measures line/frame geometry and a
// per-frame pixel checksum, then reports lock status and sticky error flags.
module vga_timing_monitor #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic        video_de,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic [5:0]  video_rgb,
  output logic        frame_done,
  output logic [11:0] meas_htotal,
  output logic [11:0] meas_hactive,
  output logic [11:0] meas_vtotal,
  output logic [11:0] meas_vactive,
  output logic [15:0] frame_sum,
  output logic        locked,
  output logic [3:0]  err_flags
);

  localparam logic [11:0] HTOT = 12'(H_TOTAL);
  localparam logic [11:0] HACT = 12'(H_ACTIVE);
  localparam logic [11:0] VTOT = 12'(V_TOTAL);
  localparam logic [11:0] VACT = 12'(V_ACTIVE);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_t;

  function automatic logic [11:0] sat_inc(input logic [11:0] v, input logic en);
    return (en && (v != 12'hFFF)) ? v + 12'd1 : v;
  endfunction

  state_t      state_q;
  logic        de_q, hs_q, vs_q, hs_dly_q, vs_dly_q;
  logic [5:0]  rgb_q;
  logic [11:0] cyc_q, de_cnt_q, line_cnt_q, vact_cnt_q, last_len_q, last_hact_q;
  logic [15:0] sum_q;
  logic        first_line_q, frame_bad_q;
  logic        frame_done_q, locked_q;
  logic [11:0] meas_htotal_q, meas_hactive_q, meas_vtotal_q, meas_vactive_q;
  logic [15:0] frame_sum_q;
  logic [3:0]  err_q;

  logic        hs_edge, vs_edge, measuring, line_active, line_err0, line_err1, frame_ok;
  logic [11:0] de_line, line_cnt_d, vact_cnt_d, last_len_d, last_hact_d;
  logic [15:0] sum_d;

  // The *_d values fold in the current cycle, so a line or pixel coinciding
  // with a vs edge is credited to the frame being closed.
  // NOTE: every signal below is assigned on every pass, so no latch can be inferred.
  always_comb begin
    hs_edge     = (hs_q == HS_POL) && (hs_dly_q != HS_POL);
    vs_edge     = (vs_q == VS_POL) && (vs_dly_q != VS_POL);
    measuring   = (state_q != SEEK);
    de_line     = sat_inc(de_cnt_q, de_q);
    line_active = hs_edge && (de_line != 12'd0);
    line_err0   = hs_edge && measuring && !first_line_q && (cyc_q != HTOT);
    line_err1   = line_active && measuring && (de_line != HACT);
    line_cnt_d  = sat_inc(line_cnt_q, hs_edge);
    vact_cnt_d  = sat_inc(vact_cnt_q, line_active);
    last_len_d  = hs_edge ? cyc_q : last_len_q;
    last_hact_d = line_active ? de_line : last_hact_q;
    sum_d       = sum_q + (de_q ? {10'd0, rgb_q} : 16'd0);
    frame_ok    = !frame_bad_q && !line_err0 && !line_err1 &&
                  (line_cnt_d == VTOT) && (vact_cnt_d == VACT) &&
                  (last_len_d == HTOT) && (last_hact_d == HACT);
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= SEEK;
      de_q           <= 1'b0;
      rgb_q          <= 6'd0;
      hs_q           <= ~HS_POL;
      hs_dly_q       <= ~HS_POL;
      vs_q           <= ~VS_POL;
      vs_dly_q       <= ~VS_POL;
      cyc_q          <= 12'd0;
      de_cnt_q       <= 12'd0;
      line_cnt_q     <= 12'd0;
      vact_cnt_q     <= 12'd0;
      last_len_q     <= 12'd0;
      last_hact_q    <= 12'd0;
      sum_q          <= 16'd0;
      first_line_q   <= 1'b0;
      frame_bad_q    <= 1'b0;
      frame_done_q   <= 1'b0;
      locked_q       <= 1'b0;
      meas_htotal_q  <= 12'd0;
      meas_hactive_q <= 12'd0;
      meas_vtotal_q  <= 12'd0;
      meas_vactive_q <= 12'd0;
      frame_sum_q    <= 16'd0;
      err_q          <= 4'd0;
    end else begin
      de_q     <= video_de;
      hs_q     <= video_hs;
      vs_q     <= video_vs;
      rgb_q    <= video_rgb;
      hs_dly_q <= hs_q;
      vs_dly_q <= vs_q;

      // Restarting at 1 makes the next latched value equal the edge-to-edge distance.
      cyc_q    <= hs_edge ? 12'd1 : sat_inc(cyc_q, 1'b1);
      de_cnt_q <= hs_edge ? 12'd0 : de_line;

      if (vs_edge) begin
        line_cnt_q  <= 12'd0;
        vact_cnt_q  <= 12'd0;
        last_len_q  <= 12'd0;
        last_hact_q <= 12'd0;
        sum_q       <= 16'd0;
        frame_bad_q <= 1'b0;
      end else begin
        line_cnt_q  <= line_cnt_d;
        vact_cnt_q  <= vact_cnt_d;
        last_len_q  <= last_len_d;
        last_hact_q <= last_hact_d;
        sum_q       <= sum_d;
        frame_bad_q <= frame_bad_q | line_err0 | line_err1;
      end

      err_q[0]     <= err_q[0] | line_err0;
      err_q[1]     <= err_q[1] | line_err1;
      frame_done_q <= 1'b0;

      case (state_q)
        SEEK: begin
          first_line_q <= 1'b1;
          if (vs_edge) state_q <= MEASURE;
        end
        MEASURE, LOCKED: begin
          if (hs_edge) first_line_q <= 1'b0;
          if (vs_edge) begin
            frame_done_q   <= 1'b1;
            meas_htotal_q  <= last_len_d;
            meas_hactive_q <= last_hact_d;
            meas_vtotal_q  <= line_cnt_d;
            meas_vactive_q <= vact_cnt_d;
            frame_sum_q    <= sum_d;
            locked_q       <= frame_ok;
            err_q[2]       <= err_q[2] | (line_cnt_d != VTOT);
            err_q[3]       <= err_q[3] | (vact_cnt_d != VACT);
            state_q        <= frame_ok ? LOCKED : MEASURE;
          end
        end
        default: state_q <= SEEK;
      endcase
    end
  end

  assign frame_done   = frame_done_q;
  assign meas_htotal  = meas_htotal_q;
  assign meas_hactive = meas_hactive_q;
  assign meas_vtotal  = meas_vtotal_q;
  assign meas_vactive = meas_vactive_q;
  assign frame_sum    = frame_sum_q;
  assign locked       = locked_q;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor on a scaled-down raster (40x20 lines, 24x12
// active) so that many frames fit in a short run.
module tb_vga_timing_monitor;

  localparam int HT = 40;
  localparam int HA = 24;
  localparam int VT = 20;
  localparam int VA = 12;

  logic        pixel_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        video_de  = 1'b0;
  logic        video_hs  = 1'b1;
  logic        video_vs  = 1'b1;
  logic [5:0]  video_rgb = 6'd0;
  logic        frame_done;
  logic [11:0] meas_htotal, meas_hactive, meas_vtotal, meas_vactive;
  logic [15:0] frame_sum;
  logic        locked;
  logic [3:0]  err_flags;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .V_TOTAL(VT), .V_ACTIVE(VA),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixel_clk   (pixel_clk),
    .sys_rst_n   (sys_rst_n),
    .video_de    (video_de),
    .video_hs    (video_hs),
    .video_vs    (video_vs),
    .video_rgb   (video_rgb),
    .frame_done  (frame_done),
    .meas_htotal (meas_htotal),
    .meas_hactive(meas_hactive),
    .meas_vtotal (meas_vtotal),
    .meas_vactive(meas_vactive),
    .frame_sum   (frame_sum),
    .locked      (locked),
    .err_flags   (err_flags)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [11:0] ht, ha, vt, va;
    logic [15:0] sum;
    logic        lk;
    logic [3:0]  err;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         f_n;
  int         f_len[32];
  int         f_de[32];
  bit         m_seek;
  logic [3:0] m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_htotal"},     32'(meas_htotal), 32'd0);
    check({tag, "_hactive"},    32'(meas_hactive), 32'd0);
    check({tag, "_vtotal"},     32'(meas_vtotal), 32'd0);
    check({tag, "_vactive"},    32'(meas_vactive), 32'd0);
    check({tag, "_sum"},        32'(frame_sum), 32'd0);
    check({tag, "_locked"},     32'(locked), 32'd0);
    check({tag, "_err"},        32'(err_flags), 32'd0);
  endtask

  // Every frame_done pulse must match the next expected frame result.
  always @(negedge pixel_clk) begin
    if (sys_rst_n && frame_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_frame_done", 32'(frame_done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("meas_htotal",  32'(meas_htotal),  32'(mon_e.ht));
        check("meas_hactive", 32'(meas_hactive), 32'(mon_e.ha));
        check("meas_vtotal",  32'(meas_vtotal),  32'(mon_e.vt));
        check("meas_vactive", 32'(meas_vactive), 32'(mon_e.va));
        check("frame_sum",    32'(frame_sum),    32'(mon_e.sum));
        check("locked",       32'(locked),       32'(mon_e.lk));
        check("err_flags",    32'(err_flags),    32'(mon_e.err));
      end
    end
  end

  function automatic void set_ideal();
    f_n = VT;
    for (int i = 0; i < 32; i++) begin
      f_len[i] = HT;
      f_de[i]  = (i >= 4 && i < 4 + VA) ? HA : 0;
    end
  endfunction

  function automatic void set_random();
    set_ideal();
    if ($urandom_range(0, 3) == 0) f_n = ($urandom_range(0, 1) == 1) ? VT + 1 : VT - 1;
    for (int i = 0; i < f_n; i++) begin
      if ($urandom_range(0, 9) == 0) f_len[i] = HT - 2 + int'($urandom_range(0, 4));
      if (f_de[i] != 0 && $urandom_range(0, 9) == 0) f_de[i] = HA - 4 + int'($urandom_range(0, 4));
    end
  endfunction

  // One line: hs active for 4 cycles at the start, de from cycle 8.
  task automatic drive_line(input int len, input int de_n, input bit vs_act,
                            input int rgb_mode, input logic [5:0] rgb_c,
                            inout logic [15:0] sum);
    for (int c = 0; c < len; c++) begin
      @(negedge pixel_clk);
      video_hs = (c < 4) ? 1'b0 : 1'b1;
      video_vs = vs_act ? 1'b0 : 1'b1;
      video_de = (c >= 8) && (c < 8 + de_n);
      if (video_de && rgb_mode == 0) video_rgb = rgb_c;
      else                           video_rgb = 6'($urandom);
      if (video_de) sum = sum + 16'(video_rgb);
    end
  endtask

  task automatic do_mid_reset();
    @(negedge pixel_clk);
    sys_rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    repeat (3) @(negedge pixel_clk);
    sys_rst_n = 1'b1;
  endtask

  // Drives the frame in f_len/f_de and predicts the result reported when
  // the following vs edge closes it.
  task automatic send_frame(input bit has_vs, input int rgb_mode, input logic [5:0] rgb_c,
                            input int rst_line);
    logic [15:0] sum;
    logic [1:0]  lerr;
    logic [3:0]  live;
    bit          measured, exempt, e0, e1;
    int          nva, last_ha;
    exp_t        e;
    sum      = 16'd0;
    lerr     = 2'b00;
    exempt   = has_vs && m_seek;
    if (has_vs) m_seek = 1'b0;
    measured = has_vs;
    live     = m_err;
    for (int i = 0; i < f_n; i++) begin
      if (i == rst_line) begin
        do_mid_reset();
        measured = 1'b0;
        m_seek   = 1'b1;
        m_err    = 4'd0;
        live     = 4'd0;
      end
      drive_line(f_len[i], f_de[i], has_vs && (i < 2), rgb_mode, rgb_c, sum);
      if (measured) begin
        e0   = (f_len[i] != HT) && !(exempt && i == 0);
        e1   = (f_de[i] != 0) && (f_de[i] != HA);
        lerr = lerr | {e1, e0};
        if (i < f_n - 1) live[1:0] = live[1:0] | {e1, e0};
      end
    end
    check("err_flags_live", 32'(err_flags), 32'(live));
    if (measured) begin
      nva     = 0;
      last_ha = 0;
      for (int i = 0; i < f_n; i++) begin
        if (f_de[i] != 0) begin
          nva++;
          last_ha = f_de[i];
        end
      end
      e.ht  = 12'(f_len[f_n-1]);
      e.ha  = 12'(last_ha);
      e.vt  = 12'(f_n);
      e.va  = 12'(nva);
      e.sum = sum;
      e.lk  = (f_n == VT) && (nva == VA) && (f_len[f_n-1] == HT) && (last_ha == HA) && (lerr == 2'b00);
      m_err = m_err | {nva != VA, f_n != VT, lerr};
      e.err = m_err;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    m_seek = 1'b1;
    m_err  = 4'd0;
    repeat (3) @(negedge pixel_clk);
    check_all_zero("reset");
    sys_rst_n = 1'b1;

    // Partial lead-in without vs, then ideal frames with full-scale pixels.
    set_ideal(); f_n = 3; send_frame(1'b0, 0, 6'h3F, -1);
    set_ideal(); send_frame(1'b1, 0, 6'h3F, -1);
    set_ideal(); send_frame(1'b1, 0, 6'h3F, -1);
    set_ideal(); send_frame(1'b1, 0, 6'h00, -1);
    set_ideal(); send_frame(1'b1, 1, 6'h00, -1);

    // One short line, then recovery; one short active line, then recovery.
    set_ideal(); f_len[7] = HT - 1; send_frame(1'b1, 1, 6'h00, -1);
    set_ideal(); send_frame(1'b1, 1, 6'h00, -1);
    set_ideal(); f_de[9] = HA - 1;  send_frame(1'b1, 1, 6'h00, -1);
    set_ideal(); send_frame(1'b1, 1, 6'h00, -1);

    repeat (3) begin
      set_random(); send_frame(1'b1, 1, 6'h00, -1);
    end
    set_ideal(); send_frame(1'b1, 1, 6'h00, -1);

    // Reset mid-frame; the next frame is consumed by SEEK with its first line exempt.
    set_ideal(); send_frame(1'b1, 1, 6'h00, 10);
    set_ideal(); f_len[0] = HT + 1; send_frame(1'b1, 1, 6'h00, -1);
    set_ideal(); send_frame(1'b1, 1, 6'h00, -1);

    // Closing vs edge for the last frame.
    repeat (4) begin
      @(negedge pixel_clk);
      video_hs = 1'b0;
      video_vs = 1'b0;
      video_de = 1'b0;
    end
    repeat (10) begin
      @(negedge pixel_clk);
      video_hs = 1'b1;
      video_vs = 1'b1;
    end
    check("pending_frame_results", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
